// File: rtl/prog_loader.sv
// Boot-time program loader: receives length/payload/checksum over valid/ready,
// writes the payload to memory from address 0, then hands the write port to the CPU.
module prog_loader #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         reload,
    input  logic [n-1:0] cpu_wr_data,
    input  logic [n-1:0] cpu_wr_addr,
    input  logic         cpu_wr_en,
    output logic [n-1:0] mem_wr_data,
    output logic [n-1:0] mem_wr_addr,
    output logic         mem_wr_en,
    output logic         cpu_reset,
    output logic         err,
    output logic         run
);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_LOAD,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t       state;
    logic [n-1:0] addr;
    logic [n-1:0] remaining;
    logic [n-1:0] sum;
    logic         xfer;

    // reload masks the handshake so it always wins over a simultaneous byte
    assign in_ready = ((state == ST_LEN) || (state == ST_LOAD) || (state == ST_CHK)) && !reload;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset || reload) begin
            state     <= ST_LEN;
            cpu_reset <= 1'b1;
            err       <= 1'b0;
            run       <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            sum       <= '0;
        end else begin
            case (state)
                ST_LEN: begin
                    if (xfer) begin
                        remaining <= in_data;
                        addr      <= '0;
                        sum       <= '0;
                        state     <= (in_data != '0) ? ST_LOAD : ST_CHK;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        sum       <= sum + in_data;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == n'(1)) begin
                            state <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        if (in_data == sum) begin
                            state     <= ST_RUN;
                            cpu_reset <= 1'b0;
                            run       <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_ERR: begin
                    state <= state;
                end
                default: begin
                    state <= ST_LEN;
                end
            endcase
        end
    end

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state)
            ST_LOAD: begin
                mem_wr_en   = xfer;
                mem_wr_addr = addr;
                mem_wr_data = in_data;
            end
            ST_RUN: begin
                mem_wr_en   = cpu_wr_en;
                mem_wr_addr = cpu_wr_addr;
                mem_wr_data = cpu_wr_data;
            end
            default: begin
                mem_wr_en   = 1'b0;
                mem_wr_addr = '0;
                mem_wr_data = '0;
            end
        endcase
    end

endmodule
